// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_pkg
//  Purpose  : Shared types and constants for the IF/ID skid pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
package if_id_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_INSTR_W = 32;
   localparam int DEF_LANES   = 1;

   localparam logic [31:0] NOP_INSTR = 32'b0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]            pc;
      logic [DEF_LANES*DEF_INSTR_W-1:0] instr;
      logic [DEF_LANES-1:0]             mask;
   } bundle_t;

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_entry
//  Purpose  : One fetch-bundle register with load enable; resets to PC 0/NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_entry
   import if_id_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int LANES   = DEF_LANES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_load,
   input  logic [ADDR_W-1:0]        i_pc,
   input  logic [LANES*INSTR_W-1:0] i_instr,
   input  logic [LANES-1:0]         i_mask,
   output logic [ADDR_W-1:0]        o_pc,
   output logic [LANES*INSTR_W-1:0] o_instr,
   output logic [LANES-1:0]         o_mask
);

   localparam logic [INSTR_W-1:0] c_NOP = INSTR_W'(NOP_INSTR);

   logic [ADDR_W-1:0]        r_pc;
   logic [LANES*INSTR_W-1:0] r_instr;
   logic [LANES-1:0]         r_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= '0;
         r_instr <= {LANES{c_NOP}};
         r_mask  <= '0;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_instr <= i_instr;
         r_mask  <= i_mask;
      end
   end

   assign o_pc    = r_pc;
   assign o_instr = r_instr;
   assign o_mask  = r_mask;

endmodule
`default_nettype wire

// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_skid_reg
//  Purpose  : IF/ID ready/valid stage register with two-entry skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_skid_reg
   import if_id_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int LANES   = DEF_LANES,
   parameter int CNT_W   = 16
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Flush,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic [ADDR_W-1:0]        In_PC,
   input  logic [LANES*INSTR_W-1:0] In_Instr,
   input  logic [LANES-1:0]         In_Mask,
   output logic                     Out_Valid,
   input  logic                     Out_Ready,
   output logic [ADDR_W-1:0]        Out_PC,
   output logic [LANES*INSTR_W-1:0] Out_Instr,
   output logic [LANES-1:0]         Out_Mask,
   output logic [CNT_W-1:0]         StallCount
);

   localparam logic [INSTR_W-1:0] c_NOP     = INSTR_W'(NOP_INSTR);
   localparam logic [CNT_W-1:0]   c_CNT_MAX = {CNT_W{1'b1}};

   state_t                   r_state;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic [CNT_W-1:0]         r_stall;

   logic                     w_accept;
   logic                     w_drain;
   logic                     w_main_load;
   logic                     w_skid_load;
   logic [ADDR_W-1:0]        w_main_pc_d;
   logic [LANES*INSTR_W-1:0] w_main_instr_d;
   logic [LANES-1:0]         w_main_mask_d;
   logic [ADDR_W-1:0]        w_main_pc;
   logic [LANES*INSTR_W-1:0] w_main_instr;
   logic [LANES-1:0]         w_main_mask;
   logic [ADDR_W-1:0]        w_skid_pc;
   logic [LANES*INSTR_W-1:0] w_skid_instr;
   logic [LANES-1:0]         w_skid_mask;
   logic [LANES-1:0]         w_out_mask;

   assign w_accept = In_Valid & r_in_ready & ~Flush;
   assign w_drain  = r_out_valid & Out_Ready;

   // In_Ready and Out_Valid are kept as flops next to the state so no
   // combinational path from Out_Ready reaches In_Ready.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (Flush) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_state     <= ONE;
                  r_out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (w_accept && !w_drain) begin
                  r_state    <= FULL;
                  r_in_ready <= 1'b0;
               end else if (!w_accept && w_drain) begin
                  r_state     <= EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            FULL: begin
               if (w_drain) begin
                  r_state    <= ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
      if (!Flush) begin
         case (r_state)
            EMPTY:   w_main_load = w_accept;
            ONE: begin
               w_main_load = w_accept & w_drain;
               w_skid_load = w_accept & ~w_drain;
            end
            FULL:    w_main_load = w_drain;
            default: w_main_load = 1'b0;
         endcase
      end
   end

   assign w_main_pc_d    = (r_state == FULL) ? w_skid_pc    : In_PC;
   assign w_main_instr_d = (r_state == FULL) ? w_skid_instr : In_Instr;
   assign w_main_mask_d  = (r_state == FULL) ? w_skid_mask  : In_Mask;

   pipe_entry #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .LANES(LANES)) u_main (
      .clk     (Clk),
      .rst     (Rst),
      .i_load  (w_main_load),
      .i_pc    (w_main_pc_d),
      .i_instr (w_main_instr_d),
      .i_mask  (w_main_mask_d),
      .o_pc    (w_main_pc),
      .o_instr (w_main_instr),
      .o_mask  (w_main_mask)
   );

   pipe_entry #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .LANES(LANES)) u_skid (
      .clk     (Clk),
      .rst     (Rst),
      .i_load  (w_skid_load),
      .i_pc    (In_PC),
      .i_instr (In_Instr),
      .i_mask  (In_Mask),
      .o_pc    (w_skid_pc),
      .o_instr (w_skid_instr),
      .o_mask  (w_skid_mask)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_stall <= '0;
      end else if (r_out_valid && !Out_Ready && (r_stall != c_CNT_MAX)) begin
         r_stall <= r_stall + 1'b1;
      end
   end

   assign w_out_mask = r_out_valid ? w_main_mask : '0;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign Out_Instr[i*INSTR_W +: INSTR_W] =
         w_out_mask[i] ? w_main_instr[i*INSTR_W +: INSTR_W] : c_NOP;
   end

   assign In_Ready   = r_in_ready;
   assign Out_Valid  = r_out_valid;
   assign Out_PC     = w_main_pc;
   assign Out_Mask   = w_out_mask;
   assign StallCount = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_skid_reg
//  Purpose  : Directed vector bench for if_id_skid_reg (2-lane and saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_reg;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Flush = 1'b0;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [31:0] In_PC = '0;
   logic [63:0] In_Instr = '0;
   logic [1:0]  In_Mask = '0;
   logic        Out_Valid;
   logic        Out_Ready = 1'b0;
   logic [31:0] Out_PC;
   logic [63:0] Out_Instr;
   logic [1:0]  Out_Mask;
   logic [15:0] StallCount;

   logic        v2 = 1'b0;
   logic        rdy2 = 1'b0;
   logic [31:0] pc2 = '0;
   logic [31:0] ins2 = '0;
   logic        irdy2;
   logic        ov2;
   logic [31:0] opc2;
   logic [31:0] oins2;
   logic        omask2;
   logic [3:0]  cnt2;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   if_id_skid_reg #(.ADDR_W(32), .INSTR_W(32), .LANES(2), .CNT_W(16)) dut (
      .Clk(Clk), .Rst(Rst), .Flush(Flush),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .In_PC(In_PC),
      .In_Instr(In_Instr), .In_Mask(In_Mask),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_PC(Out_PC),
      .Out_Instr(Out_Instr), .Out_Mask(Out_Mask), .StallCount(StallCount)
   );

   if_id_skid_reg #(.ADDR_W(32), .INSTR_W(32), .LANES(1), .CNT_W(4)) dut_sat (
      .Clk(Clk), .Rst(Rst), .Flush(1'b0),
      .In_Valid(v2), .In_Ready(irdy2), .In_PC(pc2),
      .In_Instr(ins2), .In_Mask(1'b1),
      .Out_Valid(ov2), .Out_Ready(rdy2), .Out_PC(opc2),
      .Out_Instr(oins2), .Out_Mask(omask2), .StallCount(cnt2)
   );

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [63:0] ins;
      logic [1:0]  m;
      logic        ordy;
      logic        fl;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_pc;
      logic [63:0] e_ins;
      logic [1:0]  e_m;
      logic [15:0] e_st;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic v, logic [31:0] pc, logic [63:0] ins, logic [1:0] m,
                               logic ordy, logic fl, logic e_ov, logic e_ir,
                               logic [31:0] e_pc, logic [63:0] e_ins, logic [1:0] e_m,
                               logic [15:0] e_st);
      vec_t r;
      r.v = v; r.pc = pc; r.ins = ins; r.m = m; r.ordy = ordy; r.fl = fl;
      r.e_ov = e_ov; r.e_ir = e_ir; r.e_pc = e_pc; r.e_ins = e_ins; r.e_m = e_m; r.e_st = e_st;
      return r;
   endfunction

   function automatic logic [63:0] bi(logic [31:0] pc);
      return {pc + 32'h2000_0000, pc + 32'h1000_0000};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(string tag, logic ov, logic ir, logic [31:0] pc,
                             logic [63:0] ins, logic [1:0] m, logic [15:0] st);
      check({tag, ".Out_Valid"},  64'(Out_Valid),  64'(ov));
      check({tag, ".In_Ready"},   64'(In_Ready),   64'(ir));
      check({tag, ".Out_PC"},     64'(Out_PC),     64'(pc));
      check({tag, ".Out_Instr"},  Out_Instr,       ins);
      check({tag, ".Out_Mask"},   64'(Out_Mask),   64'(m));
      check({tag, ".StallCount"}, 64'(StallCount), 64'(st));
   endtask

   initial begin
      // single bundle, then 2-lane mask forcing
      tbl.push_back(mk(1, 32'h100, {32'h0, 32'h00A00093}, 2'b01, 1, 0,
                       1, 1, 32'h100, {32'h0, 32'h00A00093}, 2'b01, 0));
      tbl.push_back(mk(0, 32'h0, 64'h0, 2'b00, 1, 0, 0, 1, 32'h100, 64'h0, 2'b00, 0));
      tbl.push_back(mk(1, 32'h200, {32'h00100113, 32'hFFFFFFFF}, 2'b10, 1, 0,
                       1, 1, 32'h200, {32'h00100113, 32'h0}, 2'b10, 0));
      // streaming, one bundle per cycle
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1, 32'(4*k), bi(32'(4*k)), 2'b11, 1, 0,
                          1, 1, 32'(4*k), bi(32'(4*k)), 2'b11, 0));
      tbl.push_back(mk(0, 32'h0, 64'h0, 2'b00, 1, 0, 0, 1, 32'h1C, 64'h0, 2'b00, 0));
      // all-lanes-masked bundle passes as valid NOP bundle
      tbl.push_back(mk(1, 32'h300, 64'hAAAA_0000_BBBB_0000, 2'b00, 1, 0,
                       1, 1, 32'h300, 64'h0, 2'b00, 0));
      tbl.push_back(mk(0, 32'h0, 64'h0, 2'b00, 1, 0, 0, 1, 32'h300, 64'h0, 2'b00, 0));
      // back-pressure: A, B absorbed, C held off until FULL drains
      tbl.push_back(mk(1, 32'h400, bi(32'h400), 2'b11, 0, 0, 1, 1, 32'h400, bi(32'h400), 2'b11, 0));
      tbl.push_back(mk(1, 32'h404, bi(32'h404), 2'b11, 0, 0, 1, 0, 32'h400, bi(32'h400), 2'b11, 1));
      tbl.push_back(mk(1, 32'h408, bi(32'h408), 2'b11, 0, 0, 1, 0, 32'h400, bi(32'h400), 2'b11, 2));
      tbl.push_back(mk(1, 32'h408, bi(32'h408), 2'b11, 0, 0, 1, 0, 32'h400, bi(32'h400), 2'b11, 3));
      tbl.push_back(mk(1, 32'h408, bi(32'h408), 2'b11, 1, 0, 1, 1, 32'h404, bi(32'h404), 2'b11, 3));
      tbl.push_back(mk(1, 32'h408, bi(32'h408), 2'b11, 1, 0, 1, 1, 32'h408, bi(32'h408), 2'b11, 3));
      tbl.push_back(mk(0, 32'h0, 64'h0, 2'b00, 1, 0, 0, 1, 32'h408, 64'h0, 2'b00, 3));
      // flush in FULL with a bundle presented
      tbl.push_back(mk(1, 32'h500, bi(32'h500), 2'b11, 0, 0, 1, 1, 32'h500, bi(32'h500), 2'b11, 3));
      tbl.push_back(mk(1, 32'h504, bi(32'h504), 2'b11, 0, 0, 1, 0, 32'h500, bi(32'h500), 2'b11, 4));
      tbl.push_back(mk(1, 32'h40, bi(32'h40), 2'b11, 0, 1, 0, 1, 32'h500, 64'h0, 2'b00, 5));
      tbl.push_back(mk(0, 32'h0, 64'h0, 2'b00, 1, 0, 0, 1, 32'h500, 64'h0, 2'b00, 5));
      // flush in ONE discards the incoming bundle
      tbl.push_back(mk(1, 32'h600, bi(32'h600), 2'b11, 1, 0, 1, 1, 32'h600, bi(32'h600), 2'b11, 5));
      tbl.push_back(mk(1, 32'h604, bi(32'h604), 2'b11, 1, 1, 0, 1, 32'h600, 64'h0, 2'b00, 5));
      tbl.push_back(mk(0, 32'h0, 64'h0, 2'b00, 1, 0, 0, 1, 32'h600, 64'h0, 2'b00, 5));

      #12;
      check_outs("reset", 0, 1, 32'h0, 64'h0, 2'b00, 16'd0);
      @(negedge Clk) Rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge Clk);
         In_Valid  = tbl[i].v;
         In_PC     = tbl[i].pc;
         In_Instr  = tbl[i].ins;
         In_Mask   = tbl[i].m;
         Out_Ready = tbl[i].ordy;
         Flush     = tbl[i].fl;
         @(posedge Clk);
         #1;
         check_outs($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_pc,
                    tbl[i].e_ins, tbl[i].e_m, tbl[i].e_st);
      end
      @(negedge Clk);
      In_Valid = 1'b0; Flush = 1'b0; Out_Ready = 1'b1;

      // saturation of a 4-bit stall counter
      @(negedge Clk);
      v2 = 1'b1; pc2 = 32'h880; ins2 = 32'h00A00093; rdy2 = 1'b0;
      @(posedge Clk);
      @(negedge Clk) v2 = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         @(posedge Clk);
         #1;
         if (j == 14) check("sat.cnt14", 64'(cnt2), 64'd14);
         if (j == 15) check("sat.cnt15", 64'(cnt2), 64'd15);
      end
      check("sat.cnt20", 64'(cnt2), 64'd15);
      check("sat.held_pc", 64'(opc2), 64'h880);
      check("sat.held_instr", 64'(oins2), 64'h00A00093);
      check("sat.valid_ready", 64'({ov2, irdy2, omask2}), 64'b111);

      // asynchronous reset between edges while FULL
      @(negedge Clk);
      In_Valid = 1'b1; In_PC = 32'h700; In_Instr = bi(32'h700); In_Mask = 2'b11; Out_Ready = 1'b0;
      @(posedge Clk);
      @(negedge Clk) In_PC = 32'h704;
      @(posedge Clk);
      #1;
      check("pre_rst.In_Ready", 64'(In_Ready), 64'd0);
      check("pre_rst.StallCount", 64'(StallCount), 64'd6);
      #2 Rst = 1'b1;
      #1;
      check_outs("async_rst", 0, 1, 32'h0, 64'h0, 2'b00, 16'd0);
      check("async_rst.sat_cnt", 64'(cnt2), 64'd0);
      @(negedge Clk);
      Rst = 1'b0; In_Valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
